// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Responder side of the core's data-memory interface. The array holds DEPTH
// 32-bit words with one write port and a combinational read port, so a
// single-cycle core sees its read data in the cycle it presents the address.
// After reset (or a clr request) a sweep zero-fills the array and only then
// raises mem_ready. A valid/ready preload port lets a loader write words
// whenever the array is ready. Saturating access counters and a sticky
// conflict flag are kept for debug.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   CEN          core chip enable (active low)
//   WEN          core write enable (active low), valid with CEN=0
//   OEN          core output enable (active low), valid with CEN=0
//   A            core word address
//   Data2Mem     core write data
//   ReadDataMem  combinational read data back to the core (0 when not reading)
//   ld_valid     preload request
//   ld_ready     preload accepted this cycle (array ready)
//   ld_addr      preload word address
//   ld_data      preload word
//   clr          synchronous re-clear request
//   mem_ready    clear sweep complete, array contents valid
//   rd_cnt       saturating count of accepted core reads
//   wr_cnt       saturating count of performed core writes
//   err_conflict sticky: a core write lost the write port to a preload
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int DEPTH = 128,
  parameter int CNT_W = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             CEN,
  input  logic             WEN,
  input  logic             OEN,
  input  logic [AW-1:0]    A,
  input  logic [31:0]      Data2Mem,
  output logic [31:0]      ReadDataMem,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [AW-1:0]    ld_addr,
  input  logic [31:0]      ld_data,
  input  logic             clr,
  output logic             mem_ready,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt,
  output logic             err_conflict
);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             err_q, err_d;

  logic [31:0]      mem [DEPTH];

  logic             is_ready;
  logic             sweep_we;
  logic             ld_fire;
  logic             core_wr_req;
  logic             core_we;
  logic             core_rd;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [31:0]      mem_wdata;

  assign is_ready    = (state_q == READY);
  // A clr edge restarts the sweep instead of writing, so it suppresses the clear write.
  assign sweep_we    = (state_q == CLEAR) && !clr;
  assign ld_fire     = is_ready && ld_valid;
  assign core_wr_req = is_ready && !CEN && !WEN;
  // Single write port: a preload in the same cycle wins regardless of address.
  assign core_we     = core_wr_req && !ld_fire;
  assign core_rd     = is_ready && !CEN && WEN && !OEN;

  assign ld_ready     = is_ready;
  assign mem_ready    = is_ready;
  assign rd_cnt       = rd_cnt_q;
  assign wr_cnt       = wr_cnt_q;
  assign err_conflict = err_q;

  assign ReadDataMem = core_rd ? mem[A] : 32'h0;

  // Sweep sequencer: walks idx through the array, then parks in READY.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (clr) begin
      state_d = CLEAR;
      idx_d   = '0;
    end else if (state_q == CLEAR) begin
      idx_d = idx_q + AW'(1);
      if (idx_q == LAST_IDX) begin
        state_d = READY;
      end
    end
  end

  // Write-port arbitration: sweep, then preload, then core.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = idx_q;
    mem_wdata = 32'h0;
    if (sweep_we) begin
      mem_we = 1'b1;
    end else if (ld_fire) begin
      mem_we    = 1'b1;
      mem_waddr = ld_addr;
      mem_wdata = ld_data;
    end else if (core_we) begin
      mem_we    = 1'b1;
      mem_waddr = A;
      mem_wdata = Data2Mem;
    end
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    err_d    = err_q;
    if (core_rd && (rd_cnt_q != '1)) begin
      rd_cnt_d = rd_cnt_q + CNT_W'(1);
    end
    if (core_we && (wr_cnt_q != '1)) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end
    if (core_wr_req && ld_fire) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CLEAR;
      idx_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      err_q    <= err_d;
    end
  end

  // The array itself has no reset; its contents are defined by the sweep.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the processor's data-memory interface: a 128 x 32-bit word-addressed data memory that services the core's CEN/WEN/OEN/A/Data2Mem requests and returns ReadDataMem in the same cycle, as a single-cycle datapath requires. It adds two functions:
- A post-reset clear sequencer that zero-fills the array and raises `mem_ready`, which the top level uses to hold the core in reset.
- A valid/ready preload port that lets the testbench or a boot loader write words before and between program runs.

It also keeps saturating access counters and a sticky conflict flag for debug.

## Interface
Parameters:
- DEPTH, 128, number of 32-bit words; the address width is log2(DEPTH) = 7.
- CNT_W, 16, width of the access counters.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- CEN  in  1  chip enable, active low.
- WEN  in  1  write enable, active low; meaningful only when CEN=0.
- OEN  in  1  output enable, active low; meaningful only when CEN=0.
- A  in  7  word address (the core drives byte address bits [8:2]).
- Data2Mem  in  32  write data from the core.
- ReadDataMem  out  32  combinational read data to the core.
- ld_valid  in  1  preload request.
- ld_ready  out  1  preload can be accepted this cycle.
- ld_addr  in  7  preload word address.
- ld_data  in  32  preload word.
- clr  in  1  synchronous re-clear request, level-sampled.
- mem_ready  out  1  clear sequence finished; the array is valid.
- rd_cnt  out  CNT_W  count of accepted core reads.
- wr_cnt  out  CNT_W  count of accepted core writes.
- err_conflict  out  1  sticky flag: a core write was dropped because a preload write won the same cycle.

## Operation
- Clear sequencer FSM, states CLEAR and READY, with a 7-bit index `idx`.
  - On reset: state=CLEAR, idx=0.
  - In CLEAR, each edge writes mem[idx]=0 and increments idx.
  - The edge that writes idx=127 moves the state to READY.
  - clr=1 in either state: at the next edge, state=CLEAR and idx=0. In CLEAR this restarts the sweep, and no write to mem[idx] occurs on that edge.
- mem_ready is registered and equals (state==READY).
- Core read: when state==READY, CEN=0, WEN=1 and OEN=0, ReadDataMem = mem[A] combinationally. In every other case ReadDataMem = 32'h0.
- Core write: when state==READY, CEN=0 and WEN=0, mem[A] <= Data2Mem at the edge.
- CEN=0 with WEN=1 and OEN=1 is a no-op and is not counted.
- Preload port:
  - ld_ready = (state==READY).
  - A transfer occurs on an edge where ld_valid and ld_ready are both 1; it writes mem[ld_addr] <= ld_data.
  - ld_valid is ignored while ld_ready=0; a request held across CLEAR is accepted once READY.
- Simultaneous preload and core write on the same edge:
  - The preload write is performed and the core write is dropped, even if the addresses differ (single write port).
  - err_conflict is set to 1 and stays 1 until reset.
  - The dropped write does not increment wr_cnt.
- Counters:
  - rd_cnt increments on each edge with an accepted core read; wr_cnt increments on each performed core write.
  - Both saturate at all-ones.
  - Only reset clears them; clr does not.
- All core accesses during CLEAR are ignored: writes are dropped, reads return 0, and nothing is counted.

## Timing
- Values during and after reset:
  - During reset: mem_ready=0, ld_ready=0, rd_cnt=0, wr_cnt=0, err_conflict=0, ReadDataMem=0.
  - Array contents are undefined until the sweep completes.
- Reset is asserted asynchronously and released synchronously at the top level.
  - The first clear write happens at the first edge after release.
  - mem_ready rises after edge 128.
- Read latency is 0 cycles (combinational from A/CEN/OEN).
  - A read in the cycle after a write to the same address returns the new data.
  - A read and a write in the same cycle (not legal from the core) return the old data.
- Write latency is 1 edge.
- Reset asserted mid-sweep or mid-run aborts immediately; the next release starts a full 128-cycle sweep.
- clr asserted in READY: mem_ready falls after the next edge and rises again 128 edges after the edge on which clr was last sampled high.

## Test plan
- Clear after reset: release rst_n, keep CEN=1 and count edges.
  - mem_ready must be 0 through edge 127 and 1 after edge 128.
  - Reads of A=0, 64 and 127 must then return 0.
- Write then read: with mem_ready=1, write 32'hDEADBEEF at A=5 (CEN=0, WEN=0).
  - The next cycle, a read of A=5 (CEN=0, WEN=1, OEN=0) returns 32'hDEADBEEF.
  - OEN=1 at the same address returns 0.
  - Afterwards wr_cnt=1 and rd_cnt=1.
- Preload handshake:
  - Hold ld_valid=1 with ld_addr=7 and ld_data=32'h12345678 from reset release.
  - ld_ready must be 0 for 128 cycles; the transfer occurs on the first READY edge.
  - A core read of A=7 then returns 32'h12345678.
- Conflict: in one cycle, issue a core write of A=3 with 32'hAAAA0000 together with a preload of A=9 with 32'h5555FFFF.
  - mem[9] must be 32'h5555FFFF and mem[3] must remain 0.
  - err_conflict must be 1 and wr_cnt must be unchanged.
- Re-clear and saturation:
  - Pulse clr after filling A=0..3 with nonzero data; after 128 edges all four read 0 and the counters keep their values.
  - Separately, 65,540 consecutive reads leave rd_cnt at 16'hFFFF.
